// File: rtl/three2eight_pulse_decoder_if.sv
// three2eight_pulse_decoder_if: handshake and one-hot output bundle for the pulse decoder.
// Signals:
//   in        encoded index from upstream (priority encoder)
//   valid     in is valid this cycle
//   ready     decoder can accept an index this cycle
//   out       registered one-hot output, zero when idle or in gap
//   out_valid high exactly while out is non-zero
//   err       sticky round-trip mismatch flag (constant 0 unless the check is built in)
// Modports: slave = decoder side, master = upstream/observer side.
interface three2eight_pulse_decoder_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  in;
    logic             valid;
    logic             ready;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             err;

    modport slave  (input in, valid, output ready, out, out_valid, err);
    modport master (output in, valid, input ready, out, out_valid, err);
endinterface

// File: rtl/three2eight_pulse_decoder.sv
// three2eight_pulse_decoder: registered 3-to-8 one-hot decoder holding each pulse HOLD cycles then one gap cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    three2eight_pulse_decoder_if.slave (in/valid/ready handshake, out/out_valid/err)
// Parameters: IN_W (index width), OUT_W (must be 2**IN_W), HOLD (1..255 cycles per pulse).
// Optional macro DEC_ROUNDTRIP_CHECK_EN: re-encodes out each ACTIVE cycle and raises sticky err on mismatch;
// without it err is tied to 0.
module three2eight_pulse_decoder #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int HOLD  = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    three2eight_pulse_decoder_if.slave  bus
);
    localparam int CW = (HOLD <= 2) ? 1 : $clog2(HOLD);

    if (OUT_W != 2 ** IN_W) begin : g_bad_width
        $error("OUT_W must equal 2**IN_W");
    end
    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("HOLD must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t           state, state_n;
    logic [OUT_W-1:0] out_q, out_n;
    logic             ov_q, ov_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IN_W-1:0]  idx, idx_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_q <= '0;
            ov_q  <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            out_q <= out_n;
            ov_q  <= ov_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // In IDLE ready is high, so valid alone marks a transfer.
    // While ACTIVE the output is re-derived from the captured index, which keeps it one-hot by construction.
    always_comb begin
        state_n = state;
        out_n   = out_q;
        ov_n    = ov_q;
        cnt_n   = cnt;
        idx_n   = idx;
        unique case (state)
            IDLE: if (bus.valid) begin
                state_n = ACTIVE;
                out_n   = OUT_W'(1) << bus.in;
                ov_n    = 1'b1;
                cnt_n   = CW'(HOLD - 1);
                idx_n   = bus.in;
            end
            ACTIVE: if (cnt != '0) begin
                cnt_n = cnt - 1'b1;
                out_n = OUT_W'(1) << idx;
            end else begin
                state_n = GAP;
                out_n   = '0;
                ov_n    = 1'b0;
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.ready     = (state == IDLE);
    assign bus.out       = out_q;
    assign bus.out_valid = ov_q;

`ifdef DEC_ROUNDTRIP_CHECK_EN
    logic [IN_W-1:0] enc;
    logic            err_q;

    // Highest set bit wins, matching the upstream priority encoder.
    always_comb begin
        enc = '0;
        for (int i = 0; i < OUT_W; i++)
            if (out_q[i]) enc = IN_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else if (state == ACTIVE && ((ov_q && out_q == '0) || enc != idx)) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule
